psram_mem_arbiter: RTL and testbench

//   Round-robin arbiter that shares the single native-bus port of the PSRAM controller between NUM_REQ masters (e.g. core, DMA).

---
 rtl/psram_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_psram_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_mem_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller native-bus port among NUM_REQ masters.
// Latency: req_valid_i -> mem_valid_o 1 cycle; mem_ready_i -> req_ready_o 1 cycle.
// Backpressure: one transfer in flight; other masters hold req_valid_i until their ready pulse.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   req_valid_i/addr/wdata/wstrb    packed per-master requests (master k in slice k)
//   req_ready_o, req_rdata_o        one-cycle completion pulse and registered read data
//   mem_valid_o/addr/wdata/wstrb    registered request toward the PSRAM controller
//   mem_ready_i, mem_rdata_i        controller completion strobe and read data
//   grant_o                         one-hot current owner, zero while idle
//   timeout_o                       one-cycle pulse when the watchdog aborts a transfer
module psram_mem_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [DATA_WIDTH-1:0]           req_rdata_o,
  output logic                            mem_valid_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0]           mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]         mem_wstrb_o,
  input  logic                            mem_ready_i,
  input  logic [DATA_WIDTH-1:0]           mem_rdata_i,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic                            timeout_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [PW-1:0] PTR_RST  = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q;
  logic [PW-1:0]   last_q;
  logic [CW-1:0]   wd_cnt_q;
  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic            wd_fire;

  // Scan upward starting just after the last winner; the first hit wins,
  // so the most recent owner is always considered last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_vld && req_valid_i[(int'(last_q) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = PW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  // A zero TIMEOUT_CYC disables the watchdog entirely.
  assign wd_fire = (TIMEOUT_CYC != 0) && (wd_cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_q      <= PTR_RST;
      wd_cnt_q    <= '0;
      req_ready_o <= '0;
      req_rdata_o <= '0;
      mem_valid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= '0;
      grant_o     <= '0;
      timeout_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            mem_addr_o  <= req_addr_i[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_o <= req_wdata_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            mem_wstrb_o <= req_wstrb_i[int'(pick_idx)*STRB_WIDTH +: STRB_WIDTH];
            mem_valid_o <= 1'b1;
            grant_o     <= NUM_REQ'(1) << pick_idx;
            last_q      <= pick_idx;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
          // Controller completion takes precedence over a same-cycle watchdog expiry.
          if (mem_ready_i) begin
            req_rdata_o <= mem_rdata_i;
            req_ready_o <= grant_o;
            mem_valid_o <= 1'b0;
            state_q     <= DONE;
          end else if (wd_fire) begin
            req_rdata_o <= '1;
            req_ready_o <= grant_o;
            timeout_o   <= 1'b1;
            mem_valid_o <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Extra cycle lets the finished master drop valid before IDLE samples again.
          req_ready_o <= '0;
          timeout_o   <= 1'b0;
          grant_o     <= '0;
          wd_cnt_q    <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_mem_arbiter.sv
// Randomized and directed bench for psram_mem_arbiter against a transaction-level model.
// Latency: checks mem_valid_o duration and ready pulse timing per transfer.
// Backpressure: bench masters hold valid until their ready pulse, then drop for one cycle.
module tb_psram_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_valid_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_wdata_i;
  logic [N*SW-1:0]   req_wstrb_i;
  logic [N-1:0]      req_ready_o;
  logic [DW-1:0]     req_rdata_o;
  logic              mem_valid_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_wdata_o;
  logic [SW-1:0]     mem_wstrb_o;
  logic              mem_ready_i;
  logic [DW-1:0]     mem_rdata_i;
  logic [N-1:0]      grant_o;
  logic              timeout_o;

  logic              m_vld   [N];
  logic [AW-1:0]     m_addr  [N];
  logic [DW-1:0]     m_wdata [N];
  logic [SW-1:0]     m_wstrb [N];

  int                checks   = 0;
  int                failures = 0;
  int                mdl_last;
  logic [N-1:0]      seen_grant;
  int                dly;
  int                r;
  bit                any_pend;

  psram_mem_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .req_ready_o(req_ready_o), .req_rdata_o(req_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    req_valid_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    for (int k = 0; k < N; k++) begin
      req_valid_i[k]          = m_vld[k];
      req_addr_i[k*AW +: AW]  = m_addr[k];
      req_wdata_i[k*DW +: DW] = m_wdata[k];
      req_wstrb_i[k*SW +: SW] = m_wstrb[k];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: nearest requesting master after the previous winner.
  function automatic int pick(input int last);
    for (int k = 1; k <= N; k++)
      if (m_vld[(last + k) % N] === 1'b1) return (last + k) % N;
    return -1;
  endfunction

  task automatic req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s);
    m_vld[k] = 1'b1; m_addr[k] = a; m_wdata[k] = d; m_wstrb[k] = s;
  endtask

  task automatic noise();
    mem_ready_i = 1'($urandom % 2);
    mem_rdata_i = $urandom;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    for (int k = 0; k < N; k++) m_vld[k] = 1'b0;
    mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mdl_last = N - 1;
    chk("rst_valid", mem_valid_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_rdata", req_rdata_o, 0);
    chk("rst_addr", mem_addr_o, 0);
  endtask

  // One transfer from arbitration to the following idle cycle. The controller
  // answers in busy cycle 'delay' (0 = first cycle); delay >= TO never answers.
  task automatic xfer(input int delay, input logic [DW-1:0] rdat, input bit drop,
                      output logic [N-1:0] g);
    int w, len;
    bit to;
    w   = pick(mdl_last);
    to  = (delay >= TO);
    len = to ? TO : delay + 1;
    if (w < 0) begin
      chk("no_request_pending", 1, 0);
      g = '0;
      return;
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clk_i); #1;
      chk("busy_valid", mem_valid_o, 1);
      chk("busy_grant", grant_o, 64'(1) << w);
      chk("busy_addr", mem_addr_o, m_addr[w]);
      chk("busy_wdata", mem_wdata_o, m_wdata[w]);
      chk("busy_wstrb", mem_wstrb_o, m_wstrb[w]);
      chk("busy_ready", req_ready_o, 0);
      chk("busy_timeout", timeout_o, 0);
      if (drop && i == 0) m_vld[w] = 1'b0;
      mem_ready_i = (i == delay);
      mem_rdata_i = (i == delay) ? rdat : $urandom;
    end
    @(posedge clk_i); #1;
    g = grant_o;
    chk("done_valid", mem_valid_o, 0);
    chk("done_grant", grant_o, 64'(1) << w);
    chk("done_ready", req_ready_o, 64'(1) << w);
    chk("done_rdata", req_rdata_o, to ? 64'hFFFF_FFFF : 64'(rdat));
    chk("done_timeout", timeout_o, 64'(to));
    m_vld[w] = 1'b0;
    mdl_last = w;
    noise();
    @(posedge clk_i); #1;
    chk("idle_valid", mem_valid_o, 0);
    chk("idle_grant", grant_o, 0);
    chk("idle_ready", req_ready_o, 0);
    chk("idle_timeout", timeout_o, 0);
    noise();
  endtask

  initial begin
    rst_i = 1'b1;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    for (int k = 0; k < N; k++) begin
      m_vld[k] = 1'b0; m_addr[k] = '0; m_wdata[k] = '0; m_wstrb[k] = '0;
    end
    repeat (2) @(posedge clk_i);
    #1;
    do_reset();

    // Single read: controller answers in the third busy cycle.
    req(0, 24'h000100, 32'h0, 4'h0);
    xfer(2, 32'hDEADBEEF, 1'b0, seen_grant);
    chk("read_owner", seen_grant, 1);

    // Contention from a fresh pointer: m0 before m1.
    do_reset();
    req(0, 24'h000200, 32'h11111111, 4'h0);
    req(1, 24'h000300, 32'h22222222, 4'h3);
    xfer(1, 32'hA5A5A5A5, 1'b0, seen_grant);
    chk("cont_first", seen_grant, 1);
    xfer(0, 32'h5A5A5A5A, 1'b0, seen_grant);
    chk("cont_second", seen_grant, 2);

    // Fairness with m0 and m1 re-requesting continuously.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 2; k++)
        if (!m_vld[k]) req(k, 24'($urandom), $urandom, 4'($urandom));
      xfer(int'($urandom % 3), $urandom, 1'b0, seen_grant);
      chk("fair_order", seen_grant, 64'(1) << (i % 2));
    end

    // Write from m1.
    do_reset();
    req(1, 24'h00FFFC, 32'h12345678, 4'hF);
    xfer(3, 32'h0, 1'b0, seen_grant);
    chk("write_owner", seen_grant, 2);

    // Watchdog abort, then a ready/timeout tie, then a mid-transfer valid drop.
    req(0, 24'h000400, 32'h0, 4'h0);
    xfer(1000, 32'h0, 1'b0, seen_grant);
    req(0, 24'h000404, 32'h0, 4'h0);
    xfer(TO - 1, 32'hCAFEF00D, 1'b0, seen_grant);
    req(2, 24'h000408, 32'h0, 4'h0);
    xfer(4, 32'h0BADF00D, 1'b1, seen_grant);
    chk("drop_owner", seen_grant, 4);

    // Reset in the middle of a transfer owned by m0.
    do_reset();
    req(0, 24'h000500, 32'h0, 4'h0);
    @(posedge clk_i); #1;
    chk("rstmid_valid_pre", mem_valid_o, 1);
    mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    req(1, 24'h000600, 32'h0, 4'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mdl_last = N - 1;
    chk("rstmid_valid", mem_valid_o, 0);
    chk("rstmid_grant", grant_o, 0);
    chk("rstmid_ready", req_ready_o, 0);
    xfer(0, 32'h13579BDF, 1'b0, seen_grant);
    chk("rstmid_first", seen_grant, 1);
    xfer(1, 32'h2468ACE0, 1'b0, seen_grant);
    chk("rstmid_second", seen_grant, 2);

    // Random traffic across all three masters.
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < N; k++)
        if (!m_vld[k] && ($urandom % 2 == 0))
          req(k, 24'($urandom), $urandom, 4'($urandom));
      any_pend = 1'b0;
      for (int k = 0; k < N; k++) if (m_vld[k]) any_pend = 1'b1;
      if (!any_pend) begin
        @(posedge clk_i); #1;
        chk("gap_valid", mem_valid_o, 0);
        chk("gap_grant", grant_o, 0);
        noise();
        req(int'($urandom % N), 24'($urandom), $urandom, 4'($urandom));
      end
      r = int'($urandom % 8);
      if (r < 5)       dly = int'($urandom % 4);
      else if (r == 5) dly = TO - 1;
      else if (r == 6) dly = TO + 5;
      else             dly = int'($urandom % TO);
      xfer(dly, $urandom, ($urandom % 8 == 0), seen_grant);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
